// File: rtl/seq_mult_su.sv
// seq_mult_su: iterative shift-and-add multiplier, signed or unsigned per operation.
// Operands are reduced to magnitudes on acceptance and multiplied over WIDTH cycles.
// The sign is applied once at the end, and the overflow flag is produced at the same time.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   BUSY  | one partial product per cycle, counter 0..WIDTH-1
//   DONE  | result held on p/ovf, out_valid=1 until consumed or aborted
module seq_mult_su #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 ovf
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [W2-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic            mode_q, mode_d;
  logic            neg_q, neg_d;
  logic [W2-1:0]   p_q, p_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic            last_iter;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2-1:0]   sum_step;
  logic [W2-1:0]   p_fin;
  logic [WIDTH:0]  p_upper;
  logic            ovf_fin;

  assign accept    = (state_q == S_IDLE) && in_valid && !abort;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Unary minus is exact here: -(2^(W-1)) is 2^(W-1) as a WIDTH-bit unsigned value.
  assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

  // The multiplicand shifts left and the multiplier shifts right, so bit k of
  // mag_b meets mag_a << k on iteration k without a variable shifter.
  assign sum_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign p_fin    = neg_q ? -sum_step : sum_step;
  assign p_upper  = p_fin[W2-1:WIDTH-1];
  assign ovf_fin  = mode_q ? !((&p_upper) || !(|p_upper))
                           : (|p_fin[W2-1:WIDTH]);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode; abort overrides completion and consumption.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid && !abort) state_d = S_BUSY;
      S_BUSY: begin
        if (abort)          state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
      S_DONE: if (abort || out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: capture on accept, iterate in BUSY, latch result on the last iteration.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mode_d   = mode_q;
    neg_d    = neg_q;
    p_d      = p_q;
    ovf_d    = ovf_q;
    if (accept) begin
      mode_d   = sgn;
      neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == S_BUSY && !abort) begin
      acc_d    = sum_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_iter) begin
        p_d   = p_fin;
        ovf_d = ovf_fin;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mode_q   <= 1'b0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mode_q   <= mode_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign p         = p_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_mult_su.sv
// Bench for seq_mult_su: one WIDTH=8 instance and one WIDTH=32 instance.
// Expected results are queued at acceptance and popped by per-instance monitors on delivery.
module tb_seq_mult_su;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, sgn8, abort8, out_valid8, out_ready8, ovf8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        in_valid32, in_ready32, sgn32, abort32, out_valid32, out_ready32, ovf32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  int checks = 0;
  int errors = 0;
  logic [16:0] q8[$];
  logic [64:0] q32[$];
  int exp8 = 0, deliv8 = 0, exp32 = 0, deliv32 = 0;

  bit rdy_mode  = 1'b0;
  bit rdy_force = 1'b1;
  bit rnd_rdy   = 1'b1;
  assign out_ready8 = rdy_mode ? rnd_rdy : rdy_force;

  seq_mult_su #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sgn(sgn8), .abort(abort8), .out_valid(out_valid8),
    .out_ready(out_ready8), .p(p8), .ovf(ovf8)
  );

  seq_mult_su #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .sgn(sgn32), .abort(abort32), .out_valid(out_valid32),
    .out_ready(out_ready32), .p(p32), .ovf(ovf32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer multiply of the operands as interpreted under the mode,
  // reduced mod 2^(2w); overflow means the true product is outside the w-bit range.
  function automatic logic [128:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                           input int w, input bit s);
    longint sx, sy, pr;
    logic [63:0]  pu;
    logic [127:0] pp;
    bit o;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    if (s) begin
      pr = sx * sy;
      pp = {{64{pr[63]}}, pr};
      o  = (pr < -(longint'(1) << (w - 1))) || (pr > ((longint'(1) << (w - 1)) - 1));
    end else begin
      pu = x * y;
      pp = {64'b0, pu};
      o  = ((pu >> w) != 64'b0);
    end
    pp = pp & ((128'b1 << (2 * w)) - 128'b1);
    return {o, pp};
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'hFF;
      3: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input bit ts,
                        input bit use_exp, input logic [16:0] expv);
    logic [128:0] r;
    int n = 0;
    @(negedge clk);
    while (!in_ready8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready8) begin
      checks++;
      errors++;
      $display("FAIL accept8_timeout actual=in_ready_low required=in_ready_high");
      return;
    end
    a8 = ta; b8 = tb; sgn8 = ts; in_valid8 = 1'b1;
    r = ref_mul({56'b0, ta}, {56'b0, tb}, 8, ts);
    q8.push_back(use_exp ? expv : {r[128], r[15:0]});
    exp8++;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] ta, input logic [31:0] tb, input bit ts,
                         input bit use_exp, input logic [64:0] expv);
    logic [128:0] r;
    int n = 0;
    @(negedge clk);
    while (!in_ready32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready32) begin
      checks++;
      errors++;
      $display("FAIL accept32_timeout actual=in_ready_low required=in_ready_high");
      return;
    end
    a32 = ta; b32 = tb; sgn32 = ts; in_valid32 = 1'b1;
    r = ref_mul({32'b0, ta}, {32'b0, tb}, 32, ts);
    q32.push_back(use_exp ? expv : {r[128], r[63:0]});
    exp32++;
    @(posedge clk);
    #1 in_valid32 = 1'b0;
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (!out_valid8 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_done8();
    int n = 0;
    while (q8.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done8_timeout actual=pending required=delivered");
    end
  endtask

  task automatic wait_done32();
    int n = 0;
    while (q32.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q32.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done32_timeout actual=pending required=delivered");
    end
  endtask

  // Monitors: while a result is presented it must match the queued expectation;
  // it is retired only on an accepted (non-aborted) handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected8 actual=%0h required=no_result", {ovf8, p8});
      end else begin
        chk("result8", 128'({ovf8, p8}), 128'(q8[0]));
        if (out_ready8 && !abort8) begin
          void'(q8.pop_front());
          deliv8++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected32 actual=%0h required=no_result", {ovf32, p32});
      end else begin
        chk("result32", 128'({ovf32, p32}), 128'(q32[0]));
        if (out_ready32 && !abort32) begin
          void'(q32.pop_front());
          deliv32++;
        end
      end
    end
  end

  initial begin
    int n;
    int seen;
    logic [16:0] held;
    rst_n = 1'b0;
    in_valid8 = 1'b0;  a8 = '0;  b8 = '0;  sgn8 = 1'b0;  abort8 = 1'b0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; sgn32 = 1'b0; abort32 = 1'b0;
    out_ready32 = 1'b1;
    #2;
    chk("rst_in_ready", 128'(in_ready8), 128'(1));
    chk("rst_out_valid", 128'(out_valid8), 128'(0));
    chk("rst_result8", 128'({ovf8, p8}), 128'(0));
    chk("rst_result32", 128'({ovf32, p32}), 128'(0));
    #10 rst_n = 1'b1;

    // Directed WIDTH=8 cases.
    issue8(8'hFF, 8'hFF, 1'b0, 1'b1, 17'h1FE01);
    wait_valid8(n);
    chk("latency8", 128'(n), 128'(8));
    wait_done8();
    issue8(8'h80, 8'h80, 1'b1, 1'b1, 17'h14000);
    issue8(8'hFD, 8'h05, 1'b1, 1'b1, 17'h0FFF1);
    issue8(8'h00, 8'h80, 1'b1, 1'b1, 17'h00000);
    wait_done8();

    // WIDTH=32 directed and random cases.
    issue32(32'h3, 32'h5, 1'b0, 1'b1, 65'h0F);
    issue32(32'h3, 32'h5, 1'b1, 1'b1, 65'h0F);
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 65'h1);
    for (int i = 0; i < 40; i++) issue32($urandom, $urandom, 1'($urandom), 1'b0, '0);
    wait_done32();

    // Backpressure: result held for 10 cycles, input pulses ignored.
    rdy_force = 1'b0;
    issue8(8'h7F, 8'h7F, 1'b1, 1'b0, '0);
    wait_valid8(n);
    chk("bp_latency", 128'(n), 128'(8));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready8), 128'(0));
    end
    @(posedge clk);
    #1 in_valid8 = 1'b0; rdy_force = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", 128'(in_ready8), 128'(1));
    chk("bp_idle_valid", 128'(out_valid8), 128'(0));

    // Abort during BUSY iteration 3.
    issue8(8'hC3, 8'h5A, 1'b1, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1 abort8 = 1'b1;
    @(posedge clk);
    #1 abort8 = 1'b0;
    q8.delete();
    exp8--;
    chk("abort_busy_ready", 128'(in_ready8), 128'(1));
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid8) seen++;
    end
    chk("abort_busy_no_valid", 128'(seen), 128'(0));
    issue8(8'h12, 8'h34, 1'b0, 1'b0, '0);
    wait_done8();

    // Abort in DONE with out_ready high: result dropped, p/ovf held.
    issue8(8'hFD, 8'h7F, 1'b1, 1'b0, '0);
    held = q8[0];
    repeat (8) @(posedge clk);
    #1;
    chk("abort_done_valid", 128'(out_valid8), 128'(1));
    abort8 = 1'b1;
    @(posedge clk);
    #1 abort8 = 1'b0;
    chk("abort_done_drop", 128'(out_valid8), 128'(0));
    chk("abort_done_ready", 128'(in_ready8), 128'(1));
    chk("abort_done_hold", 128'({ovf8, p8}), 128'(held));
    q8.delete();
    exp8--;
    issue8(8'h80, 8'h7F, 1'b1, 1'b0, '0);
    wait_done8();

    // Asynchronous reset mid-BUSY.
    issue8(8'h55, 8'hAA, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid8), 128'(0));
    chk("arst_in_ready", 128'(in_ready8), 128'(1));
    chk("arst_result", 128'({ovf8, p8}), 128'(0));
    q8.delete();
    exp8--;
    @(negedge clk);
    rst_n = 1'b1;

    // Random operands, both modes, random consumer stalls.
    rdy_mode = 1'b1;
    for (int i = 0; i < 1000; i++) issue8(pick8(), pick8(), 1'($urandom), 1'b0, '0);
    wait_done8();
    rdy_mode = 1'b0;

    chk("deliveries8", 128'(deliv8), 128'(exp8));
    chk("deliveries32", 128'(deliv32), 128'(exp32));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_su.md
# seq_mult_su

Parametrised, iterative signed/unsigned multiplier with valid/ready handshakes. It replaces the fully parallel 32x32 array multiplier and its free-running mode toggle. Each operation carries its own signedness bit, and the block reports whether the product fits back into WIDTH bits. It sits in the datapath between operand registers and the result write-back stage, and trades area for a WIDTH-cycle latency.

## Interface
Parameters:
- WIDTH, default 32, operand width in bits; legal range 4..64. The product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands a, b and sgn are valid.
- in_ready  output  1  block can accept operands. High only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- sgn  input  1  1 = two's-complement operands, 0 = unsigned. Captured with the operands.
- abort  input  1  synchronous cancel of any operation in flight.
- out_valid  output  1  p and ovf hold a completed result.
- out_ready  input  1  consumer accepts the result.
- p  output  2*WIDTH  product.
- ovf  output  1  product does not fit in WIDTH bits under the captured mode.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: iteration counter runs 0..WIDTH-1.
  - DONE: out_valid=1.
- Accept: in IDLE, in_valid=1 at a rising edge moves the block to BUSY. The edge also captures:
  - mode_q = sgn
  - neg_q = sgn & (a[W-1] ^ b[W-1])
  - mag_a = |a| and mag_b = |b| when sgn=1; raw a and b when sgn=0
  - a 2W-bit accumulator cleared to 0, counter cleared to 0.
- BUSY iteration k (one per cycle): if mag_b[k]=1, accumulator += mag_a << k. The counter then increments.
- On the edge that completes iteration WIDTH-1, the block moves to DONE and registers:
  - p = neg_q ? -(accumulator) : accumulator, two's complement mod 2^(2W)
  - ovf:
    - unsigned: OR of p[2W-1:W]
    - signed: 1 unless p[2W-1:W-1] are all equal.
- Magnitudes are WIDTH-bit unsigned. |-2^(W-1)| = 2^(W-1) must be represented exactly, with no saturation.
- A zero product with neg_q=1 gives p=0, never a "negative zero" pattern.
- DONE: p and ovf stay stable while out_valid=1 and out_ready=0. If out_ready=1 at an edge, the block moves to IDLE.
- out_valid and in_ready are never both high. There is no overlap of consecutive operations.
- abort=1 at an edge in BUSY or DONE:
  - block moves to IDLE
  - out_valid falls
  - p and ovf keep their last values; no result is delivered
  - abort has priority over out_ready and over iteration completion.
- abort=1 in IDLE together with in_valid=1: the operands are not accepted and the block stays in IDLE.
- When out_valid=0, p and ovf keep their previous values and carry no meaning.

## Timing
- Reset (asynchronous, rst low): state=IDLE, in_ready=1, out_valid=0, p=0, ovf=0, counter=0, accumulator=0. Outputs reach these values without a clock edge.
- Reset released mid-BUSY or mid-DONE: the operation is lost and no result appears.
- Latency: acceptance edge E0, then out_valid is high after edge E0+WIDTH. Example: WIDTH=32 gives 32 cycles.
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high:
  - accept
  - WIDTH BUSY edges
  - out_valid visible for one cycle
  - return to IDLE
  - in_ready high again in the next cycle.
- Operand inputs are sampled only on the acceptance edge. Changes to a, b or sgn during BUSY have no effect.
- in_ready and out_valid are decoded from registered state only. There are no combinational paths from in_valid or out_ready to any output.

## Test plan
- WIDTH=8, sgn=0, a=0xFF, b=0xFF -> p=0xFE01, ovf=1, out_valid rises exactly 8 cycles after acceptance.
- WIDTH=8, sgn=1:
  - a=0x80, b=0x80 -> p=0x4000, ovf=1
  - a=0xFD (-3), b=0x05 -> p=0xFFF1, ovf=0
  - a=0x00, b=0x80 -> p=0x0000, ovf=0.
- WIDTH=32, sgn=0, a=0x0000_0003, b=0x0000_0005 -> p=0x0F, ovf=0. Same operands with sgn=1 give the same p. Then a=0xFFFF_FFFF, b=0xFFFF_FFFF with sgn=1 -> p=1, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE:
  - p and ovf stay stable
  - in_valid pulses are ignored (in_ready=0)
  - raising out_ready gives IDLE the next cycle.
- Abort at BUSY iteration 3, and separately abort in DONE with out_ready=1 -> IDLE next cycle, out_valid never seen high (first case) or drops (second case); a fresh operation afterwards computes correctly.
- Assert rst low mid-BUSY, asynchronously between edges -> out_valid=0, in_ready=1, p=0 immediately. Then 1000 random operands in both modes, with random out_ready stalls, are checked against a behavioural a*b model.
